seg_write_arbiter: RTL and testbench

SEG_WRITE_ARBITER -- requirements
Module: seg_write_arbiter

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_write_arbiter_rr_arb2.sv | 26 ++
 rtl/seg_write_arbiter.sv | 93 +++++++++
 tb/tb_seg_write_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the segment-register write arbiter: segment codes,
// FSM state encoding and the requester count.
package seg_pkg;

  localparam logic [1:0] SEG_ES = 2'd0;
  localparam logic [1:0] SEG_CS = 2'd1;
  localparam logic [1:0] SEG_SS = 2'd2;
  localparam logic [1:0] SEG_DS = 2'd3;

  localparam int NUM_REQ = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_WRITE = 1'b1;

  function automatic logic [3:0] seg_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/seg_write_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, and on a tie the
// requester named by ptr wins.
module rr_arb2
  import seg_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               winner
);

  always_comb begin
    winner = 1'b0;
    grant  = '0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ptr;
      default: winner = 1'b0;
    endcase
    if (req != '0) begin
      grant = 2'b01 << winner;
    end
  end

endmodule

// File: rtl/seg_write_arbiter.sv
// Arbitrates two requesters onto the shared segment-register write bus: one
// IDLE cycle to latch the winner, one WRITE cycle to drive ENA/ACK.
module seg_write_arbiter
  import seg_pkg::*;
#(
  parameter bit ALLOW_CS1 = 1'b0,
  parameter bit RESET_PTR = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic [1:0]  SEL0,
  input  logic [15:0] DATA0,
  output logic        ACK0,
  input  logic        REQ1,
  input  logic [1:0]  SEL1,
  input  logic [15:0] DATA1,
  output logic        ACK1,
  output logic [15:0] WDATA,
  output logic [3:0]  ENA,
  output logic        ERR,
  output logic        BUSY
);

  state_t      state_q, state_d;
  logic        winner_q, winner_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] data_q, data_d;
  logic        ptr_q, ptr_d;

  logic [NUM_REQ-1:0] reqVec;
  logic [NUM_REQ-1:0] grant;
  logic               winner;
  logic               writeCycle;
  logic               protViol;

  assign reqVec = {REQ1, REQ0};

  rr_arb2 u_rr_arb2 (
    .req    (reqVec),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  // ptr_q names the requester that wins the next tie, i.e. the one not granted last.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    sel_d    = sel_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    if (state_q == ST_IDLE) begin
      if (grant != '0) begin
        state_d  = ST_WRITE;
        winner_d = winner;
        sel_d    = winner ? SEL1 : SEL0;
        data_d   = winner ? DATA1 : DATA0;
        ptr_d    = ~winner;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      winner_q <= 1'b0;
      sel_q    <= SEG_ES;
      data_q   <= 16'h0000;
      ptr_q    <= RESET_PTR;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
    end
  end

  // Outputs depend only on registered state, so reset clears them at once.
  assign writeCycle = (state_q == ST_WRITE);
  assign protViol   = winner_q && (sel_q == SEG_CS) && !ALLOW_CS1;

  assign ENA   = (writeCycle && !protViol) ? seg_onehot(sel_q) : 4'b0000;
  assign ACK0  = writeCycle && !winner_q;
  assign ACK1  = writeCycle && winner_q;
  assign ERR   = writeCycle && protViol;
  assign BUSY  = writeCycle;
  assign WDATA = data_q;

endmodule

// File: tb/tb_seg_write_arbiter.sv
// Scoreboard bench for seg_write_arbiter: directed requests push expected
// write-cycle responses, a negedge monitor pops and compares them.
module tb_seg_write_arbiter;

  typedef struct packed {
    logic [3:0]  ena;
    logic [15:0] wdata;
    logic        ack0;
    logic        ack1;
    logic        err;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [1:0]  SEL0 = 2'd0, SEL1 = 2'd0;
  logic [15:0] DATA0 = 16'h0, DATA1 = 16'h0;
  logic        ACK0, ACK1, ERR, BUSY;
  logic [15:0] WDATA;
  logic [3:0]  ENA;

  logic        ack0B, ack1B, errB, busyB;
  logic [15:0] wdataB;
  logic [3:0]  enaB;

  wr_t         expQ[$];
  int          checks = 0;
  int          passes = 0;
  logic [15:0] segModel [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  seg_write_arbiter #(.ALLOW_CS1(1'b0), .RESET_PTR(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .SEL0(SEL0), .DATA0(DATA0), .ACK0(ACK0),
    .REQ1(REQ1), .SEL1(SEL1), .DATA1(DATA1), .ACK1(ACK1),
    .WDATA(WDATA), .ENA(ENA), .ERR(ERR), .BUSY(BUSY)
  );

  seg_write_arbiter #(.ALLOW_CS1(1'b1), .RESET_PTR(1'b0)) dutCs (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .SEL0(SEL0), .DATA0(DATA0), .ACK0(ack0B),
    .REQ1(REQ1), .SEL1(SEL1), .DATA1(DATA1), .ACK1(ack1B),
    .WDATA(wdataB), .ENA(enaB), .ERR(errB), .BUSY(busyB)
  );

  always #5 CLK = ~CLK;

  // External segment registers capture WDATA on the edge ending a WRITE cycle.
  always @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (ENA[k]) segModel[k] <= WDATA;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: any visible write-cycle activity must match the next expected entry.
  initial begin
    wr_t got, exp;
    int  n;
    n = 0;
    forever begin
      @(negedge CLK);
      if (RST && (ACK0 || ACK1 || ERR || ENA != 4'b0000)) begin
        got = '{ena: ENA, wdata: WDATA, ack0: ACK0, ack1: ACK1, err: ERR};
        checks++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL write%0d unexpected: got ena=%b wdata=%h ack0=%b ack1=%b err=%b",
                   n, got.ena, got.wdata, got.ack0, got.ack1, got.err);
        end else begin
          exp = expQ.pop_front();
          if (got === exp) passes++;
          else $display("[TB] FAIL write%0d: got ena=%b wdata=%h ack0=%b ack1=%b err=%b, expected ena=%b wdata=%h ack0=%b ack1=%b err=%b",
                        n, got.ena, got.wdata, got.ack0, got.ack1, got.err,
                        exp.ena, exp.wdata, exp.ack0, exp.ack1, exp.err);
        end
        n++;
      end
    end
  end

  // Issue one request, hold it until its ACK, then release it.
  task automatic applyStimulus(input logic who, input logic [1:0] sel, input logic [15:0] data,
                               input logic [3:0] expEna, input logic expErr);
    logic got;
    expQ.push_back('{ena: expEna, wdata: data, ack0: !who, ack1: who, err: expErr});
    if (!who) begin
      REQ0 = 1'b1; SEL0 = sel; DATA0 = data;
    end else begin
      REQ1 = 1'b1; SEL1 = sel; DATA1 = data;
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLK);
      if (who ? ACK1 : ACK0) got = 1'b1;
    end
    if (!who) REQ0 = 1'b0;
    else      REQ1 = 1'b0;
    if (!got) begin
      checks++;
      $display("[TB] FAIL ack_timeout req%0d: got no ack, expected ack within 8 cycles", who);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackCount;

    repeat (2) @(negedge CLK);
    checkOutput("rst_ena",   {28'h0, ENA}, 32'h0);
    checkOutput("rst_ack",   {30'h0, ACK0, ACK1}, 32'h0);
    checkOutput("rst_err",   {31'h0, ERR}, 32'h0);
    checkOutput("rst_busy",  {31'h0, BUSY}, 32'h0);
    checkOutput("rst_wdata", {16'h0, WDATA}, 32'h0);
    RST = 1'b1;
    @(negedge CLK);

    applyStimulus(1'b0, 2'd3, 16'h1234, 4'b1000, 1'b0);
    @(negedge CLK);
    checkOutput("ds_reg", {16'h0, segModel[3]}, 32'h1234);

    applyStimulus(1'b0, 2'd1, 16'hC0DE, 4'b0010, 1'b0);
    applyStimulus(1'b1, 2'd1, 16'hFFFF, 4'b0000, 1'b1);
    checkOutput("cs1_allowed_ena", {28'h0, enaB}, 32'h2);
    checkOutput("cs1_allowed_err", {31'h0, errB}, 32'h0);
    @(negedge CLK);
    checkOutput("cs_reg_kept", {16'h0, segModel[1]}, 32'hC0DE);

    // Contention from reset: requester 0 first, then strict alternation.
    RST = 1'b0;
    REQ0 = 1'b1; SEL0 = 2'd0; DATA0 = 16'hAAAA;
    REQ1 = 1'b1; SEL1 = 2'd2; DATA1 = 16'h5555;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      expQ.push_back('{ena: 4'b0001, wdata: 16'hAAAA, ack0: 1'b1, ack1: 1'b0, err: 1'b0});
      expQ.push_back('{ena: 4'b0100, wdata: 16'h5555, ack0: 1'b0, ack1: 1'b1, err: 1'b0});
    end
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);

    // Reset in the middle of a WRITE cycle aborts the write.
    REQ0 = 1'b1; SEL0 = 2'd2; DATA0 = 16'hBEEF;
    @(posedge CLK);
    #2;
    checkOutput("midwr_ena_before", {28'h0, ENA}, 32'h4);
    RST = 1'b0;
    #1;
    checkOutput("midwr_ena", {28'h0, ENA}, 32'h0);
    checkOutput("midwr_ack", {30'h0, ACK0, ACK1}, 32'h0);
    checkOutput("midwr_busy", {31'h0, BUSY}, 32'h0);
    REQ0 = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("ss_reg_kept", {16'h0, segModel[2]}, 32'h5555);

    // Back-to-back: a held request yields a write every other cycle.
    for (int i = 0; i < 3; i++)
      expQ.push_back('{ena: 4'b0100, wdata: 16'h0BB0, ack0: 1'b1, ack1: 1'b0, err: 1'b0});
    REQ0 = 1'b1; SEL0 = 2'd2; DATA0 = 16'h0BB0;
    ackCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("b2b_busy%0d", i), {31'h0, BUSY}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (ACK0) ackCount++;
    end
    REQ0 = 1'b0;
    checkOutput("b2b_ack_count", ackCount, 32'd3);
    repeat (3) @(negedge CLK);
    checkOutput("ss_reg_final", {16'h0, segModel[2]}, 32'h0BB0);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
